// File: rtl/selfcomp_pkg.sv
// Shared types and constants for the self-composition leak monitor.
package selfcomp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StReport
    } state_e;

    localparam int unsigned DEFAULT_CNT_W   = 8;
    localparam int unsigned DEFAULT_CNT_MAX = (1 << DEFAULT_CNT_W) - 1;

    // Saturation value of a w-bit latency counter; doubles as the timeout.
    function automatic int unsigned sat_max(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/selfcomp_chan_tracker.sv
// Per-channel completion tracker: done bit, latency and result latches, result consume.
module selfcomp_chan_tracker
    import selfcomp_pkg::*;
#(
    parameter int unsigned W     = 128,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             collect,
    input  logic             fill,
    input  logic [CNT_W-1:0] cnt,
    input  logic             dut_valid,
    input  logic [W-1:0]     dut_result,
    output logic             dut_ready,
    output logic             done,
    output logic             done_next,
    output logic [CNT_W-1:0] lat,
    output logic [CNT_W-1:0] lat_next,
    output logic [W-1:0]     res,
    output logic [W-1:0]     res_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic capture;

    always_comb begin
        capture   = collect & dut_valid & ~done;
        dut_ready = capture;
        done_next = clear ? 1'b0 : (done | capture);
        res_next  = capture ? dut_result : res;
        lat_next  = lat;
        if (capture) begin
            lat_next = cnt;
        end else if (fill && !done) begin
            // Unfinished on timeout: report the saturation value.
            lat_next = CNT_MAX;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            lat  <= '0;
            res  <= '0;
        end else begin
            done <= done_next;
            lat  <= lat_next;
            res  <= res_next;
        end
    end

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// N-way self-composition harness: broadcasts one transaction to NCH copies and
// flags timing divergence (and optionally result divergence) between them.
module selfcomp_leak_monitor
    import selfcomp_pkg::*;
#(
    parameter int unsigned NCH          = 2,
    parameter int unsigned W            = 128,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned TOL          = 0,
    parameter int unsigned CHECK_RESULT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NCH-1:0]     dut_in_valid,
    input  logic [NCH-1:0]     dut_in_ready,
    input  logic [NCH-1:0]     dut_out_valid,
    input  logic [NCH*W-1:0]   dut_out_result,
    output logic [NCH-1:0]     dut_out_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_result,
    output logic [CNT_W-1:0]   latency_min,
    output logic [CNT_W-1:0]   latency_spread,
    output logic               timing_leak,
    output logic               timing_leak_early,
    output logic               result_leak,
    output logic               timeout,
    output logic               all_valid,
    output logic [15:0]        txn_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [NCH-1:0]   done, done_next;
    logic [CNT_W-1:0] lat      [NCH];
    logic [CNT_W-1:0] lat_next [NCH];
    logic [W-1:0]     res      [NCH];
    logic [W-1:0]     res_next [NCH];

    logic             accept, collecting, cnt_sat, all_done_next, to_report, timeout_hit;
    logic             res_mismatch;
    logic [CNT_W-1:0] lat_lo, lat_hi, spread_next, early_min;

    logic [CNT_W-1:0] latency_min_q, latency_spread_q;
    logic             timing_leak_q, result_leak_q, timeout_q;
    logic [15:0]      txn_count_q;

    assign collecting    = (state_q == StCollect);
    assign accept        = in_valid & in_ready;
    assign cnt_sat       = (cnt_q == CNT_MAX);
    assign all_done_next = &done_next;
    assign to_report     = collecting & (all_done_next | cnt_sat);
    assign timeout_hit   = collecting & cnt_sat & ~all_done_next;
    assign spread_next   = lat_hi - lat_lo;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        selfcomp_chan_tracker #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_tracker (
            .clock      (clock),
            .reset      (reset),
            .clear      (accept),
            .collect    (collecting),
            .fill       (timeout_hit),
            .cnt        (cnt_q),
            .dut_valid  (dut_out_valid[i]),
            .dut_result (dut_out_result[i*W +: W]),
            .dut_ready  (dut_out_ready[i]),
            .done       (done[i]),
            .done_next  (done_next[i]),
            .lat        (lat[i]),
            .lat_next   (lat_next[i]),
            .res        (res[i]),
            .res_next   (res_next[i])
        );
    end

    // Min/max over next-state latches so the report registers on REPORT entry.
    always_comb begin
        lat_lo       = lat_next[0];
        lat_hi       = lat_next[0];
        res_mismatch = 1'b0;
        early_min    = CNT_MAX;
        for (int i = 0; i < NCH; i++) begin
            if (lat_next[i] < lat_lo) lat_lo = lat_next[i];
            if (lat_next[i] > lat_hi) lat_hi = lat_next[i];
            if (res_next[i] != res_next[0]) res_mismatch = 1'b1;
            if (done[i] && lat[i] < early_min) early_min = lat[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept)    state_d = StCollect;
            StCollect: if (to_report) state_d = StReport;
            StReport:  if (out_ready) state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready          = (state_q == StIdle) & (&dut_in_ready);
        dut_in_valid      = {NCH{in_valid & in_ready}};
        out_valid         = (state_q == StReport);
        timing_leak_early = collecting & (|done) & ~(&done) & ((cnt_q - early_min) > TOL_C);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q            <= '0;
            latency_min_q    <= '0;
            latency_spread_q <= '0;
            timing_leak_q    <= 1'b0;
            result_leak_q    <= 1'b0;
            timeout_q        <= 1'b0;
            txn_count_q      <= '0;
        end else begin
            if (accept) begin
                cnt_q <= CNT_W'(1);
            end else if (collecting && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (to_report) begin
                latency_min_q    <= lat_lo;
                latency_spread_q <= spread_next;
                if (spread_next > TOL_C) timing_leak_q <= 1'b1;
                if ((CHECK_RESULT != 0) && res_mismatch) result_leak_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q     <= 1'b1;
                timing_leak_q <= 1'b1;
            end
            if (out_valid && out_ready) txn_count_q <= txn_count_q + 16'd1;
        end
    end

    assign out_result     = res[0];
    assign latency_min    = latency_min_q;
    assign latency_spread = latency_spread_q;
    assign timing_leak    = timing_leak_q;
    assign result_leak    = result_leak_q;
    assign timeout        = timeout_q;
    assign all_valid      = &done;
    assign txn_count      = txn_count_q;

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Directed bench: a 2-channel instance with result checking and a 4-bit counter,
// and a 4-channel instance with a tolerance of 2 cycles.
module tb_selfcomp_leak_monitor;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- instance A: NCH=2, W=8, CNT_W=4, TOL=0, CHECK_RESULT=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_dut_in_valid, a_dut_in_ready, a_dut_out_valid, a_dut_out_ready;
    logic [15:0] a_dut_out_result;
    logic [7:0]  a_out_result;
    logic [3:0]  a_lat_min, a_spread;
    logic        a_tleak, a_early, a_rleak, a_timeout, a_all_valid;
    logic [15:0] a_txn;

    selfcomp_leak_monitor #(
        .NCH(2), .W(8), .CNT_W(4), .TOL(0), .CHECK_RESULT(1)
    ) u_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .dut_in_valid(a_dut_in_valid), .dut_in_ready(a_dut_in_ready),
        .dut_out_valid(a_dut_out_valid), .dut_out_result(a_dut_out_result),
        .dut_out_ready(a_dut_out_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .latency_min(a_lat_min), .latency_spread(a_spread),
        .timing_leak(a_tleak), .timing_leak_early(a_early), .result_leak(a_rleak),
        .timeout(a_timeout), .all_valid(a_all_valid), .txn_count(a_txn)
    );

    int         a_tgt [2];
    logic [7:0] a_res [2];
    int         a_age;
    logic       a_busy;

    // Copy model: channel i presents its result when age == a_tgt[i] (0 = never).
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_busy <= 1'b0;
            a_age  <= 0;
        end else if (a_in_valid && a_in_ready) begin
            a_busy <= 1'b1;
            a_age  <= 1;
        end else if (a_busy) begin
            a_age <= a_age + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) a_dut_out_valid[i] = a_busy && (a_age == a_tgt[i]);
        a_dut_out_result = {a_res[1], a_res[0]};
    end

    // ---------------- instance B: NCH=4, W=8, CNT_W=8, TOL=2, CHECK_RESULT=0
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_dut_in_valid, b_dut_in_ready, b_dut_out_valid, b_dut_out_ready;
    logic [31:0] b_dut_out_result;
    logic [7:0]  b_out_result;
    logic [7:0]  b_lat_min, b_spread;
    logic        b_tleak, b_early, b_rleak, b_timeout, b_all_valid;
    logic [15:0] b_txn;

    selfcomp_leak_monitor #(
        .NCH(4), .W(8), .CNT_W(8), .TOL(2), .CHECK_RESULT(0)
    ) u_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .dut_in_valid(b_dut_in_valid), .dut_in_ready(b_dut_in_ready),
        .dut_out_valid(b_dut_out_valid), .dut_out_result(b_dut_out_result),
        .dut_out_ready(b_dut_out_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .latency_min(b_lat_min), .latency_spread(b_spread),
        .timing_leak(b_tleak), .timing_leak_early(b_early), .result_leak(b_rleak),
        .timeout(b_timeout), .all_valid(b_all_valid), .txn_count(b_txn)
    );

    int   b_tgt [4];
    int   b_age;
    logic b_busy;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_busy <= 1'b0;
            b_age  <= 0;
        end else if (b_in_valid && b_in_ready) begin
            b_busy <= 1'b1;
            b_age  <= 1;
        end else if (b_busy) begin
            b_age <= b_age + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) b_dut_out_valid[i] = b_busy && (b_age == b_tgt[i]);
        b_dut_out_result = 32'h0;
    end

    // Issue one transaction; n = number of cycles after issue until out_valid.
    task automatic run_a(output int n);
        @(negedge clock);
        a_in_valid = 1'b1;
        #1 check_eq("a_bcast", 32'(a_dut_in_valid), 32'h3);
        @(negedge clock);
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_b(output int n, output int early_n);
        @(negedge clock);
        b_in_valid = 1'b1;
        #1 check_eq("b_bcast", 32'(b_dut_in_valid), 32'hf);
        @(negedge clock);
        b_in_valid = 1'b0;
        n       = 1;
        early_n = 0;
        while (!b_out_valid && n < 300) begin
            if (b_early && early_n == 0) early_n = n;
            @(negedge clock);
            n++;
        end
    endtask

    task automatic consume_a;
        a_out_ready = 1'b1;
        @(negedge clock);
        a_out_ready = 1'b0;
    endtask

    task automatic consume_b;
        b_out_ready = 1'b1;
        @(negedge clock);
        b_out_ready = 1'b0;
    endtask

    int n, early_n;

    initial begin
        reset          = 1'b0;
        a_in_valid     = 1'b0;
        a_out_ready    = 1'b0;
        a_dut_in_ready = 2'b11;
        b_in_valid     = 1'b0;
        b_out_ready    = 1'b0;
        b_dut_in_ready = 4'hf;
        a_tgt = '{0, 0};
        a_res = '{8'h0, 8'h0};
        b_tgt = '{0, 0, 0, 0};
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        check_eq("rst_out_valid", 32'(a_out_valid), 32'h0);
        check_eq("rst_txn", 32'(a_txn), 32'h0);
        check_eq("rst_flags", 32'({a_tleak, a_rleak, a_timeout, a_all_valid}), 32'h0);
        check_eq("rst_in_ready", 32'(a_in_ready), 32'h1);
        check_eq("rst_dut_out_ready", 32'(a_dut_out_ready), 32'h0);

        // One copy not ready: no accept and no partial broadcast
        a_dut_in_ready = 2'b01;
        a_in_valid     = 1'b1;
        #1;
        check_eq("partial_in_ready", 32'(a_in_ready), 32'h0);
        check_eq("partial_bcast", 32'(a_dut_in_valid), 32'h0);
        a_in_valid     = 1'b0;
        a_dut_in_ready = 2'b11;

        // Reset mid-COLLECT aborts the transaction
        a_tgt = '{10, 10};
        @(negedge clock);
        a_in_valid = 1'b1;
        @(negedge clock);
        a_in_valid = 1'b0;
        @(negedge clock);
        check_eq("abort_busy_in_ready", 32'(a_in_ready), 32'h0);
        reset = 1'b0;
        #1;
        check_eq("abort_in_ready", 32'(a_in_ready), 32'h1);
        check_eq("abort_out_valid", 32'(a_out_valid), 32'h0);
        check_eq("abort_txn", 32'(a_txn), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("abort_no_report", 32'(a_out_valid), 32'h0);

        // Equal latency 3, equal results
        a_tgt = '{3, 3};
        a_res = '{8'h5, 8'h5};
        run_a(n);
        check_eq("eq_report_cycle", 32'(n), 32'd4);
        check_eq("eq_lat_min", 32'(a_lat_min), 32'd3);
        check_eq("eq_spread", 32'(a_spread), 32'd0);
        check_eq("eq_tleak", 32'(a_tleak), 32'h0);
        check_eq("eq_all_valid", 32'(a_all_valid), 32'h1);
        check_eq("eq_txn_before", 32'(a_txn), 32'd0);
        consume_a();
        check_eq("eq_txn", 32'(a_txn), 32'd1);
        check_eq("eq_idle", 32'(a_out_valid), 32'h0);

        // Equal latency, differing results
        a_tgt = '{2, 2};
        a_res = '{8'hA, 8'hB};
        run_a(n);
        check_eq("res_report_cycle", 32'(n), 32'd3);
        check_eq("res_rleak", 32'(a_rleak), 32'h1);
        check_eq("res_tleak", 32'(a_tleak), 32'h0);
        check_eq("res_out_result", 32'(a_out_result), 32'hA);
        consume_a();

        // Latencies 3 and 5 with TOL=0
        a_tgt = '{3, 5};
        a_res = '{8'h1, 8'h1};
        run_a(n);
        check_eq("div_report_cycle", 32'(n), 32'd6);
        check_eq("div_lat_min", 32'(a_lat_min), 32'd3);
        check_eq("div_spread", 32'(a_spread), 32'd2);
        check_eq("div_tleak", 32'(a_tleak), 32'h1);
        consume_a();

        // Clean transaction: leak flag stays sticky
        a_tgt = '{3, 3};
        run_a(n);
        check_eq("sticky_spread", 32'(a_spread), 32'd0);
        check_eq("sticky_tleak", 32'(a_tleak), 32'h1);
        consume_a();
        check_eq("sticky_txn", 32'(a_txn), 32'd4);

        // Channel 1 never returns: timeout at counter saturation (15)
        a_tgt = '{3, 0};
        run_a(n);
        check_eq("to_report_cycle", 32'(n), 32'd16);
        check_eq("to_timeout", 32'(a_timeout), 32'h1);
        check_eq("to_tleak", 32'(a_tleak), 32'h1);
        check_eq("to_lat_min", 32'(a_lat_min), 32'd3);
        check_eq("to_spread", 32'(a_spread), 32'd12);
        check_eq("to_all_valid", 32'(a_all_valid), 32'h0);
        consume_a();

        // Instance B, TOL=2: latencies 4,4,5,6 stay within tolerance
        b_tgt = '{4, 4, 5, 6};
        run_b(n, early_n);
        check_eq("tol_report_cycle", 32'(n), 32'd7);
        check_eq("tol_lat_min", 32'(b_lat_min), 32'd4);
        check_eq("tol_spread", 32'(b_spread), 32'd2);
        check_eq("tol_tleak", 32'(b_tleak), 32'h0);
        check_eq("tol_no_early", 32'(early_n), 32'd0);
        consume_b();
        check_eq("tol_txn", 32'(b_txn), 32'd1);

        // Latencies 4,4,4,7: early warning at cnt=7, then leak
        b_tgt = '{4, 4, 4, 7};
        run_b(n, early_n);
        check_eq("late_early_cnt", 32'(early_n), 32'd7);
        check_eq("late_report_cycle", 32'(n), 32'd8);
        check_eq("late_spread", 32'(b_spread), 32'd3);
        check_eq("late_tleak", 32'(b_tleak), 32'h1);
        check_eq("late_timeout", 32'(b_timeout), 32'h0);
        consume_b();
        check_eq("late_txn", 32'(b_txn), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
